lieat_sram_rd_arbiter: RTL and testbench

- Two-master read arbiter in front of the shared SRAM AXI read port.
- Master 0 is the IFU fetch path; master 1 is the LSU/VPU load path.
- Serialises read transactions onto the single slave AR/R channel pair, one outstanding transaction at a time, because the SRAM model accepts only one.
- Routes R data back to the granted master. The slave write channels bypass this block.

---
 rtl/lieat_arb_pkg.sv | 14 +
 rtl/lieat_rr_arb2.sv | 46 ++++
 rtl/lieat_sram_rd_arbiter.sv | 115 +++++++++++
 tb/tb_lieat_sram_rd_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lieat_arb_pkg.sv
// Shared encodings for the SRAM read arbiter.
// Feature macro LIEAT_ARB_LSU_PRIO_EN selects fixed LSU priority.
package lieat_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_DATA = 2'd2
    } arb_state_e;

    localparam logic ARB_ID_IFU = 1'b0;
    localparam logic ARB_ID_LSU = 1'b1;

endpackage

// File: rtl/lieat_rr_arb2.sv
// Two-way request picker with a 1-bit round-robin pointer.
// With LIEAT_ARB_LSU_PRIO_EN the LSU always wins and no pointer is kept.
module lieat_rr_arb2
    import lieat_arb_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    input  logic       adv_id,
    output logic [1:0] gnt
);

`ifdef LIEAT_ARB_LSU_PRIO_EN

    wire unused_ok = ^{clock, reset, advance, adv_id};

    always_comb begin
        gnt = req;
        if (req[ARB_ID_LSU]) gnt = 2'b10;
    end

`else

    logic ptr_q;
    logic ptr_d;

    // After a completed read the other master becomes preferred.
    always_comb begin
        ptr_d = ptr_q;
        if (advance) ptr_d = ~adv_id;
    end

    always_ff @(posedge clock) begin
        if (reset) ptr_q <= ARB_ID_IFU;
        else       ptr_q <= ptr_d;
    end

    always_comb begin
        gnt = req;
        if (&req) gnt = ptr_q ? 2'b10 : 2'b01;
    end

`endif

endmodule

// File: rtl/lieat_sram_rd_arbiter.sv
// Serialises IFU/LSU AXI reads onto the single SRAM AR/R port.
// LIEAT_ARB_LSU_PRIO_EN: fixed LSU priority instead of round-robin.
module lieat_sram_rd_arbiter
    import lieat_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int ID_W   = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              m0_arvalid,
    output logic              m0_arready,
    input  logic [ADDR_W-1:0] m0_araddr,
    input  logic [2:0]        m0_arsize,
    output logic              m0_rvalid,
    input  logic              m0_rready,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_arvalid,
    output logic              m1_arready,
    input  logic [ADDR_W-1:0] m1_araddr,
    input  logic [2:0]        m1_arsize,
    output logic              m1_rvalid,
    input  logic              m1_rready,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              s_arvalid,
    input  logic              s_arready,
    output logic [ADDR_W-1:0] s_araddr,
    output logic [2:0]        s_arsize,
    output logic [ID_W-1:0]   s_arid,
    input  logic              s_rvalid,
    output logic              s_rready,
    input  logic [DATA_W-1:0] s_rdata
);

    arb_state_e        state_q, state_d;
    logic              grant_q, grant_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        size_q, size_d;
    logic [1:0]        req;
    logic [1:0]        gnt;
    logic              advance;
    logic              in_idle, in_addr, in_data;

    // Outputs are gated by reset so nothing handshakes while it is held.
    assign in_idle = !reset && (state_q == ARB_IDLE);
    assign in_addr = !reset && (state_q == ARB_ADDR);
    assign in_data = !reset && (state_q == ARB_DATA);

    assign req = {m1_arvalid, m0_arvalid} & {2{in_idle}};

    lieat_rr_arb2 u_pick (
        .clock   (clock),
        .reset   (reset),
        .req     (req),
        .advance (advance),
        .adv_id  (grant_q),
        .gnt     (gnt)
    );

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        addr_d     = addr_q;
        size_d     = size_q;
        advance    = 1'b0;
        m0_arready = gnt[ARB_ID_IFU];
        m1_arready = gnt[ARB_ID_LSU];
        s_arvalid  = in_addr;
        s_rready   = in_data & (grant_q ? m1_rready : m0_rready);
        m0_rvalid  = in_data & s_rvalid & (grant_q == ARB_ID_IFU);
        m1_rvalid  = in_data & s_rvalid & (grant_q == ARB_ID_LSU);
        unique case (state_q)
            ARB_IDLE: begin
                if (|gnt) begin
                    grant_d = gnt[ARB_ID_LSU];
                    addr_d  = gnt[ARB_ID_LSU] ? m1_araddr : m0_araddr;
                    size_d  = gnt[ARB_ID_LSU] ? m1_arsize : m0_arsize;
                    state_d = ARB_ADDR;
                end
            end
            ARB_ADDR: begin
                if (s_arready) state_d = ARB_DATA;
            end
            ARB_DATA: begin
                if (s_rvalid && s_rready) begin
                    advance = 1'b1;
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            grant_q <= ARB_ID_IFU;
            addr_q  <= '0;
            size_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
        end
    end

    assign s_araddr = addr_q;
    assign s_arsize = size_q;
    assign s_arid   = ID_W'(grant_q);
    assign m0_rdata = s_rdata;
    assign m1_rdata = s_rdata;

endmodule

// File: tb/tb_lieat_sram_rd_arbiter.sv
// Directed bench for lieat_sram_rd_arbiter with an AR/R scoreboard
// and a small one-outstanding SRAM responder.
module tb_lieat_sram_rd_arbiter;

`ifdef LIEAT_ARB_LSU_PRIO_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready;
    logic [31:0] m0_araddr;
    logic [2:0]  m0_arsize;
    logic [63:0] m0_rdata;
    logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready;
    logic [31:0] m1_araddr;
    logic [2:0]  m1_arsize;
    logic [63:0] m1_rdata;
    logic        s_arvalid, s_arready, s_rvalid, s_rready;
    logic [31:0] s_araddr;
    logic [2:0]  s_arsize;
    logic [3:0]  s_arid;
    logic [63:0] s_rdata;

    always #5 clock = ~clock;

    lieat_sram_rd_arbiter dut (
        .clock(clock), .reset(reset),
        .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
        .m0_araddr(m0_araddr), .m0_arsize(m0_arsize),
        .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rdata(m0_rdata),
        .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
        .m1_araddr(m1_araddr), .m1_arsize(m1_arsize),
        .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rdata(m1_rdata),
        .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_araddr(s_araddr), .s_arsize(s_arsize), .s_arid(s_arid),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata)
    );

    typedef struct {
        logic        id;
        logic [31:0] addr;
        logic [2:0]  size;
    } ar_t;
    typedef struct {
        logic        id;
        logic [63:0] data;
    } r_t;

    ar_t         arq[$];
    r_t          rq[$];
    logic        glog[$];
    logic [31:0] arlog[$];

    int          n_cmp = 0;
    int          n_err = 0;
    bit          sram_pend = 1'b0;
    logic [63:0] sram_data = '0;
    int          ar_stall = 0;
    bit          cont_mode = 1'b0;
    int          cont_left = 0;
    logic [31:0] c0_addr, c1_addr;

    function automatic logic [63:0] fdata(input logic [31:0] a);
        return {a ^ 32'h91223344, a ^ 32'hD5667788};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Sample settled outputs, update the models, then advance one cycle.
    task automatic tick();
        bit  h0, h1, sar, rh, d0, d1, stall_dec;
        ar_t e;
        r_t  r;
        #1;
        h0  = m0_arvalid & m0_arready;
        h1  = m1_arvalid & m1_arready;
        sar = s_arvalid & s_arready;
        rh  = s_rvalid & s_rready;
        d0  = m0_rvalid & m0_rready;
        d1  = m1_rvalid & m1_rready;
        stall_dec = s_arvalid && (ar_stall > 0);
        if (h0) arq.push_back('{1'b0, m0_araddr, m0_arsize});
        if (h1) arq.push_back('{1'b1, m1_araddr, m1_arsize});
        if (sar) begin
            if (arq.size() == 0) chk("ar_unexpected", 1, 0);
            else begin
                e = arq.pop_front();
                chk("s_arid", s_arid, e.id);
                chk("s_araddr", s_araddr, e.addr);
                chk("s_arsize", s_arsize, e.size);
                glog.push_back(e.id);
                arlog.push_back(s_araddr);
                rq.push_back('{e.id, fdata(e.addr)});
            end
            sram_pend = 1'b1;
            sram_data = fdata(s_araddr);
        end
        if (rh || d0 || d1) chk("r_hs_match", d0 | d1, rh);
        if (rh) sram_pend = 1'b0;
        if (d0 || d1) begin
            if (rq.size() == 0) chk("r_unexpected", 1, 0);
            else begin
                r = rq.pop_front();
                chk("r_master", d1, r.id);
                chk("r_data", d1 ? m1_rdata : m0_rdata, r.data);
                chk("r_other_quiet", d1 ? m0_rvalid : m1_rvalid, 0);
            end
        end
        if (cont_mode && (h0 || h1)) cont_left--;
        @(negedge clock);
        if (h0) begin
            if (cont_mode && cont_left > 0) begin
                c0_addr += 32'h8;
                m0_araddr = c0_addr;
            end else m0_arvalid = 1'b0;
        end
        if (h1) begin
            if (cont_mode && cont_left > 0) begin
                c1_addr += 32'h8;
                m1_araddr = c1_addr;
            end else m1_arvalid = 1'b0;
        end
        if (stall_dec) ar_stall--;
        s_arready = (ar_stall == 0);
        s_rvalid  = sram_pend;
        s_rdata   = sram_pend ? sram_data : 64'h0;
    endtask

    task automatic drain();
        bit quiet;
        quiet = 1'b0;
        for (int i = 0; i < 80; i++) begin
            #1;
            quiet = !m0_arvalid && !m1_arvalid && !s_arvalid && !sram_pend
                    && arq.size() == 0 && rq.size() == 0;
            if (quiet) break;
            tick();
        end
        chk("drain_timeout", quiet, 1);
    endtask

    initial begin
        reset = 1'b1;
        m0_arvalid = 1'b1; m0_araddr = 32'h100; m0_arsize = 3'd2;
        m1_arvalid = 1'b1; m1_araddr = 32'h200; m1_arsize = 3'd2;
        m0_rready = 1'b1;  m1_rready = 1'b1;
        s_arready = 1'b1;  s_rvalid = 1'b0; s_rdata = '0;
        @(negedge clock);

        // Held reset with both masters requesting: everything quiet.
        repeat (3) begin
            #1;
            chk("rst_m0_arready", m0_arready, 0);
            chk("rst_m1_arready", m1_arready, 0);
            chk("rst_s_arvalid", s_arvalid, 0);
            chk("rst_s_rready", s_rready, 0);
            tick();
        end

        // Both requesting at reset release.
        reset = 1'b0;
        #1;
        chk("rel_m0_arready", m0_arready, !PRIO);
        chk("rel_m1_arready", m1_arready, PRIO);
        drain();
        chk("t2_count", glog.size(), 2);
        chk("t2_g0", glog[0], PRIO);
        chk("t2_g1", glog[1], !PRIO);
        chk("t2_a0", arlog[0], PRIO ? 32'h200 : 32'h100);
        chk("t2_a1", arlog[1], PRIO ? 32'h100 : 32'h200);

        // Continuous requests from both masters.
        glog.delete(); arlog.delete();
        cont_mode = 1'b1; cont_left = 6;
        c0_addr = 32'h1000; c1_addr = 32'h2000;
        m0_arvalid = 1'b1; m0_araddr = c0_addr; m0_arsize = 3'd2;
        m1_arvalid = 1'b1; m1_araddr = c1_addr; m1_arsize = 3'd3;
        drain();
        cont_mode = 1'b0;
        chk("t3_count", glog.size(), 7);
        for (int i = 0; i < 6; i++)
            chk($sformatf("t3_g%0d", i), glog[i], PRIO ? 1'b1 : 1'(i % 2));
        chk("t3_g6", glog[6], 0);

        // Single m0 read with exact cycle timing.
        m0_arvalid = 1'b1; m0_araddr = 32'h8000_0000; m0_arsize = 3'd2;
        #1;
        chk("t1_c0_m0_arready", m0_arready, 1);
        chk("t1_c0_m1_arready", m1_arready, 0);
        tick();
        #1;
        chk("t1_c1_s_arvalid", s_arvalid, 1);
        chk("t1_c1_s_arid", s_arid, 0);
        chk("t1_c1_s_araddr", s_araddr, 32'h8000_0000);
        tick();
        #1;
        chk("t1_m0_rvalid", m0_rvalid, 1);
        chk("t1_m0_rdata", m0_rdata, 64'h1122334455667788);
        chk("t1_m1_rvalid", m1_rvalid, 0);
        tick();
        drain();

        // AR stall in ADDR while the other master also waits.
        glog.delete(); arlog.delete();
        ar_stall = 5; s_arready = 1'b0;
        m1_arvalid = 1'b1; m1_araddr = 32'h300; m1_arsize = 3'd3;
        m0_arvalid = 1'b1; m0_araddr = 32'h400; m0_arsize = 3'd1;
        #1;
        chk("t4_m1_arready", m1_arready, 1);
        chk("t4_m0_arready", m0_arready, 0);
        tick();
        repeat (5) begin
            #1;
            chk("t4_s_arvalid", s_arvalid, 1);
            chk("t4_s_araddr", s_araddr, 32'h300);
            chk("t4_s_arid", s_arid, 1);
            chk("t4_s_arsize", s_arsize, 3);
            chk("t4_no_arready", m0_arready | m1_arready, 0);
            tick();
        end
        #1;
        chk("t4_release", s_arvalid & s_arready, 1);
        drain();
        chk("t4_g0", glog[0], 1);
        chk("t4_g1", glog[1], 0);

        // m1 holds off R for 4 cycles.
        m1_rready = 1'b0;
        m1_arvalid = 1'b1; m1_araddr = 32'h500; m1_arsize = 3'd3;
        #1;
        chk("t5_m1_arready", m1_arready, 1);
        tick();
        tick();
        repeat (4) begin
            #1;
            chk("t5_m1_rvalid", m1_rvalid, 1);
            chk("t5_s_rready_low", s_rready, 0);
            tick();
        end
        m1_rready = 1'b1;
        m0_arvalid = 1'b1; m0_araddr = 32'h600; m0_arsize = 3'd2;
        #1;
        chk("t5_s_rready", s_rready, 1);
        chk("t5_m1_rdata", m1_rdata, fdata(32'h500));
        chk("t5_no_ar_on_r", m0_arready, 0);
        tick();
        #1;
        chk("t5_idle_m0_arready", m0_arready, 1);
        chk("t5_idle_s_rready", s_rready, 0);
        chk("t5_idle_m1_rvalid", m1_rvalid, 0);
        drain();

        // Reset while a read sits in DATA.
        m0_rready = 1'b0;
        m0_arvalid = 1'b1; m0_araddr = 32'h700; m0_arsize = 3'd2;
        tick();
        tick();
        #1;
        chk("t6_in_data", m0_rvalid, 1);
        reset = 1'b1;
        m0_rready = 1'b1;
        #1;
        chk("t6_rst_m0_rvalid", m0_rvalid, 0);
        chk("t6_rst_s_rready", s_rready, 0);
        tick();
        reset = 1'b0;
        sram_pend = 1'b0; s_rvalid = 1'b0;
        arq.delete(); rq.delete(); glog.delete(); arlog.delete();
        #1;
        chk("t6_s_arvalid", s_arvalid, 0);
        chk("t6_m0_rvalid", m0_rvalid, 0);
        chk("t6_m1_rvalid", m1_rvalid, 0);
        chk("t6_s_rready", s_rready, 0);
        m0_arvalid = 1'b1; m0_araddr = 32'h800; m0_arsize = 3'd2;
        m1_arvalid = 1'b1; m1_araddr = 32'h900; m1_arsize = 3'd3;
        #1;
        chk("t6_ptr_m0", m0_arready, !PRIO);
        chk("t6_ptr_m1", m1_arready, PRIO);
        drain();
        chk("t6_count", glog.size(), 2);
        chk("t6_m1_served", glog[PRIO ? 0 : 1], 1);

        // Stray SRAM R beat while idle must be ignored.
        s_rvalid = 1'b1; s_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
        #1;
        chk("stray_s_rready", s_rready, 0);
        chk("stray_m0_rvalid", m0_rvalid, 0);
        chk("stray_m1_rvalid", m1_rvalid, 0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
